// File: rtl/bru_sched.sv
// Branch reservation station: buffers branch/jump ops until both operands are ready,
// issues the oldest ready entry, and tracks speculative branch masks.
module bru_sched #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned TAG_W     = 6,
  parameter int unsigned BMASK_W   = 4,
  parameter int unsigned BTAG_W    = 2,
  parameter int unsigned PAYLOAD_W = 96
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      disp_valid,
  output logic                      disp_ready,
  input  logic [PAYLOAD_W-1:0]      disp_payload,
  input  logic [TAG_W-1:0]          disp_ps1,
  input  logic [TAG_W-1:0]          disp_ps2,
  input  logic                      disp_ps1_rdy,
  input  logic                      disp_ps2_rdy,
  input  logic [31:0]               disp_ps1_data,
  input  logic [31:0]               disp_ps2_data,
  input  logic [BMASK_W-1:0]        disp_bmask,
  input  logic                      cdb_valid,
  input  logic [TAG_W-1:0]          cdb_tag,
  input  logic [31:0]               cdb_data,
  input  logic                      br_broadcast,
  input  logic [BTAG_W-1:0]         br_tag,
  input  logic                      br_clean,
  input  logic                      br_kill,
  output logic                      iss_valid,
  input  logic                      iss_ready,
  output logic [PAYLOAD_W-1:0]      iss_payload,
  output logic [31:0]               iss_a,
  output logic [31:0]               iss_b,
  output logic [BMASK_W-1:0]        iss_bmask,
  output logic [$clog2(DEPTH):0]    occupancy
);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = IDX_W + 1;

  logic [DEPTH-1:0]                valid_q, valid_d;
  logic [DEPTH-1:0][PAYLOAD_W-1:0] payload_q, payload_d;
  logic [DEPTH-1:0][TAG_W-1:0]     ps1_q, ps1_d, ps2_q, ps2_d;
  logic [DEPTH-1:0]                rdy1_q, rdy1_d, rdy2_q, rdy2_d;
  logic [DEPTH-1:0][31:0]          data1_q, data1_d, data2_q, data2_d;
  logic [DEPTH-1:0][BMASK_W-1:0]   bmask_q, bmask_d;
  // older_q[j][i] set means entry j was dispatched before entry i
  logic [DEPTH-1:0][DEPTH-1:0]     older_q, older_d;
  logic [CNT_W-1:0]                occ_q, occ_d;

  logic [DEPTH-1:0] eligible, blocked, sel_oh;
  logic [IDX_W-1:0] sel_idx, free_idx;
  logic             do_issue, do_disp, disp_kill;
  logic             new_rdy1, new_rdy2;
  logic [31:0]      new_data1, new_data2;
  logic [BMASK_W-1:0] new_bmask;

  always_comb begin
    eligible = valid_q & rdy1_q & rdy2_q;
    blocked  = '0;
    sel_oh   = '0;
    sel_idx  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      for (int unsigned j = 0; j < DEPTH; j++) begin
        blocked[i] = blocked[i] | (eligible[j] & older_q[j][i]);
      end
      sel_oh[i] = eligible[i] & ~blocked[i];
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (sel_oh[i]) sel_idx = IDX_W'(i);
    end
    free_idx = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!valid_q[DEPTH-1-i]) free_idx = IDX_W'(DEPTH-1-i);
    end
  end

  assign iss_valid   = |eligible;
  assign iss_payload = payload_q[sel_idx];
  assign iss_a       = data1_q[sel_idx];
  assign iss_b       = data2_q[sel_idx];
  assign iss_bmask   = bmask_q[sel_idx];
  assign disp_ready  = (occ_q < CNT_W'(DEPTH));
  assign occupancy   = occ_q;

  always_comb begin
    do_issue  = iss_valid & iss_ready;
    disp_kill = br_broadcast & disp_bmask[br_tag] & br_kill & ~br_clean;
    do_disp   = disp_valid & disp_ready & ~disp_kill;

    new_rdy1  = disp_ps1_rdy;
    new_data1 = disp_ps1_data;
    if (!disp_ps1_rdy && cdb_valid && cdb_tag == disp_ps1) begin
      new_rdy1  = 1'b1;
      new_data1 = cdb_data;
    end
    new_rdy2  = disp_ps2_rdy;
    new_data2 = disp_ps2_data;
    if (!disp_ps2_rdy && cdb_valid && cdb_tag == disp_ps2) begin
      new_rdy2  = 1'b1;
      new_data2 = cdb_data;
    end
    new_bmask = disp_bmask;
    if (br_broadcast && br_clean) new_bmask[br_tag] = 1'b0;

    valid_d   = valid_q;
    payload_d = payload_q;
    ps1_d     = ps1_q;
    ps2_d     = ps2_q;
    rdy1_d    = rdy1_q;
    rdy2_d    = rdy2_q;
    data1_d   = data1_q;
    data2_d   = data2_q;
    bmask_d   = bmask_q;
    older_d   = older_q;

    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_q[i]) begin
        if (cdb_valid && !rdy1_q[i] && ps1_q[i] == cdb_tag) begin
          rdy1_d[i]  = 1'b1;
          data1_d[i] = cdb_data;
        end
        if (cdb_valid && !rdy2_q[i] && ps2_q[i] == cdb_tag) begin
          rdy2_d[i]  = 1'b1;
          data2_d[i] = cdb_data;
        end
        if (br_broadcast && bmask_q[i][br_tag]) begin
          if (br_clean) bmask_d[i][br_tag] = 1'b0;
          else if (br_kill) valid_d[i] = 1'b0;
        end
        if (do_issue && sel_idx == IDX_W'(i)) valid_d[i] = 1'b0;
      end
    end

    if (do_disp) begin
      valid_d[free_idx]   = 1'b1;
      payload_d[free_idx] = disp_payload;
      ps1_d[free_idx]     = disp_ps1;
      ps2_d[free_idx]     = disp_ps2;
      rdy1_d[free_idx]    = new_rdy1;
      rdy2_d[free_idx]    = new_rdy2;
      data1_d[free_idx]   = new_data1;
      data2_d[free_idx]   = new_data2;
      bmask_d[free_idx]   = new_bmask;
      for (int unsigned j = 0; j < DEPTH; j++) begin
        older_d[free_idx][j] = 1'b0;
        if (IDX_W'(j) != free_idx) older_d[j][free_idx] = 1'b1;
      end
    end

    occ_d = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      occ_d = occ_d + CNT_W'(valid_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      older_q <= '0;
      occ_q   <= '0;
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
      ps1_q     <= ps1_d;
      ps2_q     <= ps2_d;
      rdy1_q    <= rdy1_d;
      rdy2_q    <= rdy2_d;
      data1_q   <= data1_d;
      data2_q   <= data2_d;
      bmask_q   <= bmask_d;
      older_q   <= older_d;
      occ_q     <= occ_d;
    end
  end

endmodule

// File: tb/tb_bru_sched.sv
// Directed and random stimulus for bru_sched, checked every cycle against an
// in-order queue model of the reservation station.
module tb_bru_sched;
  logic        clk = 1'b0;
  logic        rst;
  logic        disp_valid, disp_ready;
  logic [95:0] disp_payload;
  logic [5:0]  disp_ps1, disp_ps2;
  logic        disp_ps1_rdy, disp_ps2_rdy;
  logic [31:0] disp_ps1_data, disp_ps2_data;
  logic [3:0]  disp_bmask;
  logic        cdb_valid;
  logic [5:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        br_broadcast;
  logic [1:0]  br_tag;
  logic        br_clean, br_kill;
  logic        iss_valid, iss_ready;
  logic [95:0] iss_payload;
  logic [31:0] iss_a, iss_b;
  logic [3:0]  iss_bmask;
  logic [2:0]  occupancy;

  int errors = 0;
  int checks = 0;
  bit known = 0;

  typedef struct {
    logic [95:0] payload;
    logic [5:0]  ps1, ps2;
    bit          r1, r2;
    logic [31:0] d1, d2;
    logic [3:0]  bm;
  } ent_t;
  ent_t mq[$];

  bru_sched #(.DEPTH(4), .TAG_W(6), .BMASK_W(4), .BTAG_W(2), .PAYLOAD_W(96)) dut (
    .clk(clk), .rst(rst),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_payload(disp_payload),
    .disp_ps1(disp_ps1), .disp_ps2(disp_ps2),
    .disp_ps1_rdy(disp_ps1_rdy), .disp_ps2_rdy(disp_ps2_rdy),
    .disp_ps1_data(disp_ps1_data), .disp_ps2_data(disp_ps2_data),
    .disp_bmask(disp_bmask),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .br_broadcast(br_broadcast), .br_tag(br_tag), .br_clean(br_clean), .br_kill(br_kill),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_payload(iss_payload),
    .iss_a(iss_a), .iss_b(iss_b), .iss_bmask(iss_bmask), .occupancy(occupancy)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int msel();
    for (int k = 0; k < mq.size(); k++)
      if (mq[k].r1 && mq[k].r2) return k;
    return -1;
  endfunction

  function automatic ent_t wake(input ent_t e);
    ent_t r = e;
    if (cdb_valid && !r.r1 && r.ps1 == cdb_tag) begin r.r1 = 1; r.d1 = cdb_data; end
    if (cdb_valid && !r.r2 && r.ps2 == cdb_tag) begin r.r2 = 1; r.d2 = cdb_data; end
    return r;
  endfunction

  task automatic compare();
    int s;
    s = msel();
    chk("occupancy", 128'(occupancy), 128'(mq.size()));
    chk("disp_ready", 128'(disp_ready), 128'(mq.size() < 4));
    chk("iss_valid", 128'(iss_valid), 128'(s >= 0));
    if (s >= 0) begin
      chk("iss_payload", 128'(iss_payload), 128'(mq[s].payload));
      chk("iss_a", 128'(iss_a), 128'(mq[s].d1));
      chk("iss_b", 128'(iss_b), 128'(mq[s].d2));
      chk("iss_bmask", 128'(iss_bmask), 128'(mq[s].bm));
    end
  endtask

  task automatic model_update();
    int s;
    ent_t nq[$];
    ent_t e;
    bit drop;
    if (rst) begin
      mq.delete();
      known = 1;
      return;
    end
    if (!known) return;
    s = msel();
    for (int k = 0; k < mq.size(); k++) begin
      if (iss_ready && s == k) continue;
      e = wake(mq[k]);
      drop = 0;
      if (br_broadcast && e.bm[br_tag]) begin
        if (br_clean) e.bm[br_tag] = 1'b0;
        else if (br_kill) drop = 1;
      end
      if (!drop) nq.push_back(e);
    end
    if (disp_valid && mq.size() < 4) begin
      e.payload = disp_payload;
      e.ps1 = disp_ps1;  e.ps2 = disp_ps2;
      e.r1 = disp_ps1_rdy; e.r2 = disp_ps2_rdy;
      e.d1 = disp_ps1_data; e.d2 = disp_ps2_data;
      e.bm = disp_bmask;
      e = wake(e);
      drop = 0;
      if (br_broadcast && e.bm[br_tag]) begin
        if (br_clean) e.bm[br_tag] = 1'b0;
        else if (br_kill) drop = 1;
      end
      if (!drop) nq.push_back(e);
    end
    mq = nq;
  endtask

  // Inputs are set by the caller; outputs are checked at the falling edge.
  task automatic tick();
    @(negedge clk);
    if (known && !rst) compare();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; disp_valid = 0; disp_payload = '0;
    disp_ps1 = '0; disp_ps2 = '0; disp_ps1_rdy = 0; disp_ps2_rdy = 0;
    disp_ps1_data = '0; disp_ps2_data = '0; disp_bmask = '0;
    cdb_valid = 0; cdb_tag = '0; cdb_data = '0;
    br_broadcast = 0; br_tag = '0; br_clean = 0; br_kill = 0;
    iss_ready = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic set_disp(input logic [5:0] p1, input bit r1, input logic [31:0] d1,
                          input logic [5:0] p2, input bit r2, input logic [31:0] d2,
                          input logic [3:0] bm);
    disp_valid = 1;
    disp_payload = {$urandom, $urandom, $urandom};
    disp_ps1 = p1; disp_ps1_rdy = r1; disp_ps1_data = d1;
    disp_ps2 = p2; disp_ps2_rdy = r2; disp_ps2_data = d2;
    disp_bmask = bm;
  endtask

  initial begin
    do_reset();
    chk("rst_occ", 128'(occupancy), 128'd0);
    chk("rst_iss_valid", 128'(iss_valid), 128'd0);
    chk("rst_disp_ready", 128'(disp_ready), 128'd1);

    // Single op with both operands ready
    iss_ready = 1;
    set_disp(6'd1, 1, 32'h10, 6'd2, 1, 32'h20, 4'b0000);
    tick();
    disp_valid = 0;
    chk("a_valid", 128'(iss_valid), 128'd1);
    chk("a_iss_a", 128'(iss_a), 128'h10);
    chk("a_iss_b", 128'(iss_b), 128'h20);
    tick();
    chk("a_occ0", 128'(occupancy), 128'd0);

    // Younger ready op bypasses an older waiting one
    set_disp(6'd5, 0, 32'h0, 6'd3, 1, 32'h33, 4'b0000);
    tick();
    set_disp(6'd6, 1, 32'hC1, 6'd7, 1, 32'hC2, 4'b0000);
    tick();
    disp_valid = 0;
    cdb_valid = 1; cdb_tag = 6'd5; cdb_data = 32'hAB;
    chk("c_first", 128'(iss_a), 128'hC1);
    tick();
    cdb_valid = 0;
    chk("b_valid", 128'(iss_valid), 128'd1);
    chk("b_iss_a", 128'(iss_a), 128'hAB);
    tick();
    chk("bc_occ0", 128'(occupancy), 128'd0);

    // Fill to capacity
    iss_ready = 0;
    for (int i = 0; i < 4; i++) begin
      set_disp(6'(10 + i), 0, 32'h0, 6'd0, 1, 32'(i), 4'b0000);
      tick();
    end
    tick();
    chk("full_ready", 128'(disp_ready), 128'd0);
    chk("full_occ", 128'(occupancy), 128'd4);
    disp_valid = 0;
    cdb_valid = 1; cdb_tag = 6'd10; cdb_data = 32'h1234;
    tick();
    cdb_valid = 0;
    chk("full_wake_valid", 128'(iss_valid), 128'd1);
    chk("full_still_full", 128'(disp_ready), 128'd0);
    iss_ready = 1;
    tick();
    chk("full_drained_ready", 128'(disp_ready), 128'd1);
    chk("full_drained_occ", 128'(occupancy), 128'd3);

    // Branch kill and clean
    do_reset();
    set_disp(6'd20, 0, 0, 6'd0, 1, 32'h1, 4'b0010); tick();
    set_disp(6'd20, 0, 0, 6'd0, 1, 32'h2, 4'b0011); tick();
    set_disp(6'd20, 0, 0, 6'd0, 1, 32'h3, 4'b0100); tick();
    disp_valid = 0;
    chk("br_occ3", 128'(occupancy), 128'd3);
    br_broadcast = 1; br_tag = 2'd1; br_kill = 1; tick();
    chk("br_kill_occ1", 128'(occupancy), 128'd1);
    br_kill = 0; br_clean = 1; br_tag = 2'd2; tick();
    br_broadcast = 0; br_clean = 0;
    cdb_valid = 1; cdb_tag = 6'd20; cdb_data = 32'h77; tick();
    cdb_valid = 0;
    chk("br_clean_valid", 128'(iss_valid), 128'd1);
    chk("br_clean_mask", 128'(iss_bmask), 128'd0);

    // Same-cycle capture, stall, then kill
    do_reset();
    set_disp(6'd8, 1, 32'h1, 6'd9, 0, 32'h0, 4'b1000);
    cdb_valid = 1; cdb_tag = 6'd9; cdb_data = 32'h55;
    tick();
    disp_valid = 0; cdb_valid = 0;
    chk("cap_valid", 128'(iss_valid), 128'd1);
    chk("cap_iss_b", 128'(iss_b), 128'h55);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", 128'(iss_valid), 128'd1);
      chk("stall_a", 128'(iss_a), 128'h1);
      chk("stall_b", 128'(iss_b), 128'h55);
    end
    br_broadcast = 1; br_tag = 2'd3; br_kill = 1; tick();
    br_broadcast = 0; br_kill = 0;
    chk("kill_valid", 128'(iss_valid), 128'd0);
    chk("kill_occ", 128'(occupancy), 128'd0);

    // Random traffic
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      disp_valid = ($urandom_range(0, 3) != 0);
      disp_payload = {$urandom, $urandom, $urandom};
      disp_ps1 = 6'($urandom_range(0, 7));
      disp_ps2 = 6'($urandom_range(0, 7));
      disp_ps1_rdy = $urandom_range(0, 1);
      disp_ps2_rdy = $urandom_range(0, 1);
      disp_ps1_data = $urandom;
      disp_ps2_data = $urandom;
      disp_bmask = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      cdb_valid = $urandom_range(0, 1);
      cdb_tag = 6'($urandom_range(0, 7));
      cdb_data = $urandom;
      br_broadcast = ($urandom_range(0, 7) == 0);
      br_tag = 2'($urandom_range(0, 3));
      br_clean = $urandom_range(0, 1);
      br_kill = $urandom_range(0, 1);
      iss_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
